// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite to device-request bridge.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Contents:
//   resp_e        AXI response codes used by the bridge.
//   state_e       Bridge FSM states.
//   wbeat_t       One buffered W beat (data + strobes).
//   resp_from_err Maps a device error flag to an AXI response.
package axil_pkg;

  localparam int DEV_ADDR_W = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  // IDLE  : waiting for an eligible buffered access
  // REQ   : device request driven, waiting for grant
  // WAIT  : granted, waiting for the device response pulse
  // BRESP : write response presented on B
  // RRESP : read response presented on R
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    BRESP = 3'd3,
    RRESP = 3'd4
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } wbeat_t;

  function automatic resp_e resp_from_err(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axil_to_dev_req_if.sv
// Bundles for the two sides of the bridge: host AXI-Lite and device req/gnt/rvalid.
// Latency: n/a (wires only).
// Backpressure: n/a.
//
// axil_lite_if : AXI-Lite AW/W/B/AR/R channels, no PROT.
//   slave  modport - the bridge (drives READY on AW/W/AR, VALID on B/R).
//   master modport - the host / testbench.
// dev_req_if   : single-word device request interface.
//   master modport - the bridge (drives req/addr/we/be/wdata).
//   slave  modport - the device register block.
interface axil_lite_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [31:0]           S_AXI_WDATA;
  logic [3:0]            S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [31:0]           S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

interface dev_req_if;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_err_i;
  logic [31:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
  );
endinterface

// File: rtl/axil_chan_buf.sv
// One-entry holding register for a single AXI-Lite request channel (AW, W or AR).
// Latency: a load is visible on full/data the cycle after the handshake.
// Backpressure: the owner derives READY from !full; entry is held until clear.
//
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       channel handshake this cycle (VALID & READY)
//   load_data  payload captured on load
//   clear      release the entry (response handshake); wins over load
//   full       entry holds a payload
//   data       held payload, stable while full
module axil_chan_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end
  end

endmodule

// File: rtl/axil_to_dev_req.sv
// AXI-Lite slave turning host register accesses into single-word device req/gnt/rvalid transactions.
// Latency: AW+W (or AR) handshake in T -> data_req_o T+2 -> BVALID/RVALID T+4 with immediate gnt and rvalid.
// Backpressure: 1-entry AW/W/AR buffers, released only on the B/R handshake; one access in flight.
//
// Ports:
//   clk    clock, all logic on posedge
//   rst    synchronous active-high reset (data_req_o is also masked combinationally)
//   s_axi  AXI-Lite slave side (axil_lite_if.slave)
//   dev    device request side (dev_req_if.master)
// Parameters:
//   ADDR_WIDTH  AXI address width (>=3); device address is zero-extended/truncated to 32 b
//   BASE_ADDR   start of decoded window (word aligned)
//   ADDR_SPAN   window size in bytes; misses get DECERR without touching the device
module axil_to_dev_req
  import axil_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ADDR_SPAN  = 32'h0001_0000
) (
  input  logic  clk,
  input  logic  rst,
  axil_lite_if.slave s_axi,
  dev_req_if.master  dev
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);

  // Offset is taken modulo 2^ADDR_WIDTH, so addresses below BASE wrap to a
  // huge offset and miss the window.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_A;
    return 64'(off) < 64'(ADDR_SPAN);
  endfunction

  function automatic logic [DEV_ADDR_W-1:0] to_dev_addr(input logic [ADDR_WIDTH-1:0] a);
    return DEV_ADDR_W'(a) & 32'hFFFF_FFFC;
  endfunction

  // ---------------------------------------------------------------------------
  // Channel buffers
  // ---------------------------------------------------------------------------
  logic                  aw_full, w_full, ar_full;
  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  wbeat_t                w_in, w_q;
  logic                  aw_load, w_load, ar_load;
  logic                  wr_clear, rd_clear;

  // Keeps every READY low while rst is held and for the first edge after it,
  // so READY stays a function of registered state only.
  logic rdy_en_q;

  assign s_axi.S_AXI_AWREADY = rdy_en_q & ~aw_full;
  assign s_axi.S_AXI_WREADY  = rdy_en_q & ~w_full;
  assign s_axi.S_AXI_ARREADY = rdy_en_q & ~ar_full;

  assign aw_load = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_load  = s_axi.S_AXI_WVALID  & s_axi.S_AXI_WREADY;
  assign ar_load = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;

  assign w_in = '{wdata: s_axi.S_AXI_WDATA, wstrb: s_axi.S_AXI_WSTRB};

  axil_chan_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (aw_load),
    .load_data (s_axi.S_AXI_AWADDR),
    .clear     (wr_clear),
    .full      (aw_full),
    .data      (aw_addr)
  );

  axil_chan_buf #(.WIDTH($bits(wbeat_t))) u_w_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .load_data (w_in),
    .clear     (wr_clear),
    .full      (w_full),
    .data      (w_q)
  );

  axil_chan_buf #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (ar_load),
    .load_data (s_axi.S_AXI_ARADDR),
    .clear     (rd_clear),
    .full      (ar_full),
    .data      (ar_addr)
  );

  // ---------------------------------------------------------------------------
  // Arbitration: round-robin between a complete write and a pending read.
  // prio_wr_q = 1 means the write wins a tie; it flips to the side not served.
  // ---------------------------------------------------------------------------
  logic wr_elig, rd_elig, pick_wr;

  assign wr_elig = aw_full & w_full;
  assign rd_elig = ar_full;

  // ---------------------------------------------------------------------------
  // FSM and response registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic        cur_we_q, cur_we_d;
  logic        prio_wr_q, prio_wr_d;
  resp_e       resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_st, bvalid, rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_we_q  <= 1'b0;
      prio_wr_q <= 1'b1;
      resp_q    <= OKAY;
      rdata_q   <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_we_q  <= cur_we_d;
      prio_wr_q <= prio_wr_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      rdy_en_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_we_d  = cur_we_q;
    prio_wr_d = prio_wr_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    wr_clear  = 1'b0;
    rd_clear  = 1'b0;
    req_st    = 1'b0;
    bvalid    = 1'b0;
    rvalid    = 1'b0;
    pick_wr   = wr_elig & (~rd_elig | prio_wr_q);

    unique case (state_q)
      IDLE: begin
        if (pick_wr) begin
          cur_we_d  = 1'b1;
          prio_wr_d = 1'b0;
          if (in_window(aw_addr)) begin
            state_d = REQ;
          end else begin
            resp_d  = DECERR;
            state_d = BRESP;
          end
        end else if (rd_elig) begin
          cur_we_d  = 1'b0;
          prio_wr_d = 1'b1;
          rdata_d   = '0;
          if (in_window(ar_addr)) begin
            state_d = REQ;
          end else begin
            resp_d  = DECERR;
            state_d = RRESP;
          end
        end
      end

      REQ: begin
        req_st = 1'b1;
        if (dev.data_gnt_i) begin
          state_d = WAIT;
        end
      end

      // rvalid is only honoured here; stray pulses in other states are dropped.
      WAIT: begin
        if (dev.data_rvalid_i) begin
          resp_d  = resp_from_err(dev.data_err_i);
          rdata_d = cur_we_q ? '0 : dev.data_rdata_i;
          state_d = cur_we_q ? BRESP : RRESP;
        end
      end

      BRESP: begin
        bvalid = 1'b1;
        if (s_axi.S_AXI_BREADY) begin
          wr_clear = 1'b1;
          state_d  = IDLE;
        end
      end

      RRESP: begin
        rvalid = 1'b1;
        if (s_axi.S_AXI_RREADY) begin
          rd_clear = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Device-side signals are zero outside REQ so nothing stale leaks.
  // ---------------------------------------------------------------------------
  assign s_axi.S_AXI_BVALID = bvalid;
  assign s_axi.S_AXI_BRESP  = bvalid ? resp_q : OKAY;
  assign s_axi.S_AXI_RVALID = rvalid;
  assign s_axi.S_AXI_RRESP  = rvalid ? resp_q : OKAY;
  assign s_axi.S_AXI_RDATA  = rvalid ? rdata_q : '0;

  // Masked by rst so the request drops in the same cycle reset is raised.
  assign dev.data_req_o   = req_st & ~rst;
  assign dev.data_we_o    = req_st & cur_we_q;
  assign dev.data_addr_o  = req_st ? to_dev_addr(cur_we_q ? aw_addr : ar_addr) : '0;
  assign dev.data_be_o    = req_st ? (cur_we_q ? w_q.wstrb : 4'hF) : 4'h0;
  assign dev.data_wdata_o = (req_st & cur_we_q) ? w_q.wdata : '0;

endmodule

// File: tb/tb_axil_to_dev_req.sv
module tb_axil_to_dev_req;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axil_lite_if #(.ADDR_WIDTH(32)) ax ();
  dev_req_if dv ();

  axil_to_dev_req #(
    .ADDR_WIDTH (32),
    .BASE_ADDR  (32'h0000_0000),
    .ADDR_SPAN  (32'h0001_0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (ax),
    .dev   (dv)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dev_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  dev_exp_t    exp_dev[$];
  logic [1:0]  exp_b[$];
  r_exp_t      exp_r[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Device model: grant after gnt_delay cycles of req, rvalid rv_delay cycles
  // after the cycle following the grant.
  // ---------------------------------------------------------------------------
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] dev_rdata = 32'h0;
  logic        dev_err   = 1'b0;

  initial begin : device
    dv.data_gnt_i    = 1'b0;
    dv.data_rvalid_i = 1'b0;
    dv.data_err_i    = 1'b0;
    dv.data_rdata_i  = 32'h0;
    forever begin
      @(posedge clk); #1;
      dv.data_gnt_i    = 1'b0;
      dv.data_rvalid_i = 1'b0;
      dv.data_err_i    = 1'b0;
      dv.data_rdata_i  = 32'h0;
      if (dv.data_req_o) begin
        repeat (gnt_delay) begin @(posedge clk); #1; end
        dv.data_gnt_i = 1'b1;
        @(posedge clk); #1;
        dv.data_gnt_i = 1'b0;
        repeat (rv_delay) begin @(posedge clk); #1; end
        dv.data_rvalid_i = 1'b1;
        dv.data_err_i    = dev_err;
        dv.data_rdata_i  = dev_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitors / scoreboard (sample on negedge)
  // ---------------------------------------------------------------------------
  logic        req_prev = 1'b0, bv_prev = 1'b0, rhold_prev = 1'b0;
  logic [31:0] addr_prev = 32'h0, rdata_prev = 32'h0;
  logic [1:0]  rresp_prev = 2'b0;
  int req_rise_cyc = -1, b_rise_cyc = -1;
  int req_run = 0, req_len = 0, addr_chg = 0, req_cycles = 0;
  int r_unstable = 0, r_hold_cycles = 0;

  always @(negedge clk) begin : monitor
    dev_exp_t de;
    r_exp_t   re;
    logic [1:0] be_;
    if (!rst) begin
      if (dv.data_req_o) begin
        req_cycles++;
        if (!req_prev) begin
          req_rise_cyc = cyc;
          req_run = 1;
        end else begin
          req_run++;
          if (dv.data_addr_o !== addr_prev) addr_chg++;
        end
        if (dv.data_gnt_i) begin
          req_len = req_run;
          check("dev_req_expected", exp_dev.size() != 0, 1);
          if (exp_dev.size() != 0) begin
            de = exp_dev.pop_front();
            check("dev_addr",  dv.data_addr_o,  de.addr);
            check("dev_we",    dv.data_we_o,    de.we);
            check("dev_be",    dv.data_be_o,    de.be);
            check("dev_wdata", dv.data_wdata_o, de.wdata);
          end
        end
      end
      if (ax.S_AXI_BVALID && !bv_prev) b_rise_cyc = cyc;
      if (ax.S_AXI_BVALID && ax.S_AXI_BREADY) begin
        check("b_expected", exp_b.size() != 0, 1);
        if (exp_b.size() != 0) begin
          be_ = exp_b.pop_front();
          check("bresp", ax.S_AXI_BRESP, be_);
        end
      end
      if (rhold_prev) begin
        if (!(ax.S_AXI_RVALID === 1'b1 && ax.S_AXI_RDATA === rdata_prev && ax.S_AXI_RRESP === rresp_prev))
          r_unstable++;
      end
      if (ax.S_AXI_RVALID && !ax.S_AXI_RREADY) r_hold_cycles++;
      if (ax.S_AXI_RVALID && ax.S_AXI_RREADY) begin
        check("r_expected", exp_r.size() != 0, 1);
        if (exp_r.size() != 0) begin
          re = exp_r.pop_front();
          check("rdata", ax.S_AXI_RDATA, re.data);
          check("rresp", ax.S_AXI_RRESP, re.resp);
        end
      end
    end
    req_prev   = dv.data_req_o;
    addr_prev  = dv.data_addr_o;
    bv_prev    = ax.S_AXI_BVALID;
    rhold_prev = ax.S_AXI_RVALID && !ax.S_AXI_RREADY;
    rdata_prev = ax.S_AXI_RDATA;
    rresp_prev = ax.S_AXI_RRESP;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive at posedge+1, sample READY at negedge)
  // ---------------------------------------------------------------------------
  task automatic send_aw(input logic [31:0] a, output int hs);
    hs = -1;
    ax.S_AXI_AWADDR  = a;
    ax.S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 300 && hs < 0; i++) begin
      @(negedge clk);
      if (ax.S_AXI_AWREADY) hs = cyc;
      @(posedge clk); #1;
    end
    ax.S_AXI_AWVALID = 1'b0;
    check("aw_handshake", hs >= 0, 1);
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
    hs = -1;
    ax.S_AXI_WDATA  = d;
    ax.S_AXI_WSTRB  = s;
    ax.S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 300 && hs < 0; i++) begin
      @(negedge clk);
      if (ax.S_AXI_WREADY) hs = cyc;
      @(posedge clk); #1;
    end
    ax.S_AXI_WVALID = 1'b0;
    check("w_handshake", hs >= 0, 1);
  endtask

  task automatic send_ar(input logic [31:0] a, output int hs);
    hs = -1;
    ax.S_AXI_ARADDR  = a;
    ax.S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 300 && hs < 0; i++) begin
      @(negedge clk);
      if (ax.S_AXI_ARREADY) hs = cyc;
      @(posedge clk); #1;
    end
    ax.S_AXI_ARVALID = 1'b0;
    check("ar_handshake", hs >= 0, 1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_dev.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_drain"}, n < 300, 1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    int t_aw, t_w, t_ar, snap, viol, found;

    rst = 1'b1;
    ax.S_AXI_AWADDR = 0; ax.S_AXI_AWVALID = 0;
    ax.S_AXI_WDATA  = 0; ax.S_AXI_WSTRB   = 0; ax.S_AXI_WVALID = 0;
    ax.S_AXI_BREADY = 1;
    ax.S_AXI_ARADDR = 0; ax.S_AXI_ARVALID = 0;
    ax.S_AXI_RREADY = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", ax.S_AXI_AWREADY, 0);
    check("rst_wready",  ax.S_AXI_WREADY,  0);
    check("rst_arready", ax.S_AXI_ARREADY, 0);
    check("rst_bvalid",  ax.S_AXI_BVALID,  0);
    check("rst_bresp",   ax.S_AXI_BRESP,   0);
    check("rst_rvalid",  ax.S_AXI_RVALID,  0);
    check("rst_rdata",   ax.S_AXI_RDATA,   0);
    check("rst_rresp",   ax.S_AXI_RRESP,   0);
    check("rst_req",     dv.data_req_o,    0);
    check("rst_addr",    dv.data_addr_o,   0);
    check("rst_we",      dv.data_we_o,     0);
    check("rst_be",      dv.data_be_o,     0);
    check("rst_wdata",   dv.data_wdata_o,  0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // 1: write, AW and W together, immediate gnt, rvalid next cycle
    exp_dev.push_back('{addr: 32'h10, we: 1'b1, be: 4'hF, wdata: 32'hDEADBEEF});
    exp_b.push_back(2'b00);
    fork
      send_aw(32'h10, t_aw);
      send_w(32'hDEADBEEF, 4'hF, t_w);
    join
    check("wr1_same_cycle", t_aw, t_w);
    viol = 0;
    found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      @(negedge clk);
      if (ax.S_AXI_BVALID && ax.S_AXI_BREADY) found = 1;
      if (ax.S_AXI_AWREADY) viol++;
    end
    check("wr1_b_seen", found, 1);
    check("wr1_awready_low", viol, 0);
    @(negedge clk);
    check("wr1_awready_after_b", ax.S_AXI_AWREADY, 1);
    check("wr1_req_latency", req_rise_cyc, t_aw + 2);
    check("wr1_b_latency", b_rise_cyc, t_aw + 4);
    @(posedge clk); #1;
    drain("wr1");

    // 2: read, gnt held low 3 cycles
    gnt_delay = 3;
    dev_rdata = 32'hCAFE0001;
    addr_chg  = 0;
    exp_dev.push_back('{addr: 32'h24, we: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_r.push_back('{data: 32'hCAFE0001, resp: 2'b00});
    send_ar(32'h24, t_ar);
    drain("rd1");
    check("rd1_req_len", req_len, 4);
    check("rd1_addr_stable", addr_chg, 0);
    gnt_delay = 0;

    // 3: W five cycles ahead of AW, device error
    dev_err = 1'b1;
    exp_dev.push_back('{addr: 32'h30, we: 1'b1, be: 4'h3, wdata: 32'h12345678});
    exp_b.push_back(2'b10);
    send_w(32'h12345678, 4'h3, t_w);
    snap = req_cycles;
    repeat (5) begin @(posedge clk); #1; end
    check("wr2_no_req_before_aw", req_cycles, snap);
    send_aw(32'h30, t_aw);
    drain("wr2");
    dev_err = 1'b0;

    // 4: out-of-window reads
    snap = req_cycles;
    exp_r.push_back('{data: 32'h0, resp: 2'b11});
    send_ar(32'h0001_0000, t_ar);
    drain("oow_hi");
    exp_r.push_back('{data: 32'h0, resp: 2'b11});
    send_ar(32'hFFFF_FFFC, t_ar);
    drain("oow_lo");
    check("oow_no_req", req_cycles, snap);

    // 5: write and read pending together, 4 rounds -> W,R,W,R
    r_unstable    = 0;
    r_hold_cycles = 0;
    for (int r = 0; r < 4; r++) begin
      dev_rdata = 32'hA000_0000 + r;
      exp_dev.push_back('{addr: 32'h100 + 8*r, we: 1'b1, be: 4'hF, wdata: 32'h5500_0000 + r});
      exp_dev.push_back('{addr: 32'h200 + 8*r, we: 1'b0, be: 4'hF, wdata: 32'h0});
      exp_b.push_back(2'b00);
      exp_r.push_back('{data: 32'hA000_0000 + r, resp: 2'b00});
      if (r == 1) ax.S_AXI_RREADY = 1'b0;
      fork
        send_aw(32'h100 + 8*r, t_aw);
        send_w(32'h5500_0000 + r, 4'hF, t_w);
        send_ar(32'h200 + 8*r, t_ar);
      join
      if (r == 1) begin
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
          @(negedge clk);
          if (ax.S_AXI_RVALID) found = 1;
        end
        check("rr_rvalid_seen", found, 1);
        repeat (10) begin @(posedge clk); #1; end
        ax.S_AXI_RREADY = 1'b1;
      end
      drain("rr");
    end
    check("rr_r_hold_10", r_hold_cycles >= 10, 1);
    check("rr_r_stable", r_unstable, 0);

    // 5b: after a lone write the read wins the next tie
    exp_dev.push_back('{addr: 32'h300, we: 1'b1, be: 4'hC, wdata: 32'h0000_1111});
    exp_b.push_back(2'b00);
    fork
      send_aw(32'h300, t_aw);
      send_w(32'h0000_1111, 4'hC, t_w);
    join
    drain("rr_solo");
    dev_rdata = 32'h0BEE_F00D;
    exp_dev.push_back('{addr: 32'h304, we: 1'b0, be: 4'hF, wdata: 32'h0});
    exp_dev.push_back('{addr: 32'h308, we: 1'b1, be: 4'hF, wdata: 32'h0000_2222});
    exp_r.push_back('{data: 32'h0BEE_F00D, resp: 2'b00});
    exp_b.push_back(2'b00);
    fork
      send_aw(32'h30B, t_aw);
      send_w(32'h0000_2222, 4'hF, t_w);
      send_ar(32'h304, t_ar);
    join
    drain("rr_flip");

    // 6: reset while in WAIT, device rvalid arrives during reset
    rv_delay = 1;
    exp_dev.push_back('{addr: 32'h40, we: 1'b1, be: 4'hF, wdata: 32'h0BADF00D});
    fork
      send_aw(32'h40, t_aw);
      send_w(32'h0BADF00D, 4'hF, t_w);
    join
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      if (dv.data_req_o && dv.data_gnt_i) found = 1;
    end
    check("rst_mid_gnt_seen", found, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_mid_bvalid",  ax.S_AXI_BVALID,  0);
    check("rst_mid_rvalid",  ax.S_AXI_RVALID,  0);
    check("rst_mid_req",     dv.data_req_o,    0);
    check("rst_mid_awready", ax.S_AXI_AWREADY, 0);
    check("rst_mid_wready",  ax.S_AXI_WREADY,  0);
    check("rst_mid_arready", ax.S_AXI_ARREADY, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv_delay = 0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ax.S_AXI_BVALID || ax.S_AXI_RVALID || dv.data_req_o) viol++;
    end
    check("rst_mid_no_response", viol, 0);
    check("end_dev_q_empty", exp_dev.size(), 0);
    check("end_b_q_empty", exp_b.size(), 0);
    check("end_r_q_empty", exp_r.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
